// File: rtl/gf180mcu_osu_sc_12t_clkbranch_seq.sv
// Staggered clock-branch enable sequencer.
// Walks EN toward REQ one bit per STAGGER cycles, round-robin.
module gf180mcu_osu_sc_12t_clkbranch_seq #(
  parameter int N       = 4,
  parameter int STAGGER = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  input  logic         FORCE_OFF,
  output logic [N-1:0] EN,
  output logic         BUSY,
  output logic         DONE
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  diff;
  logic [PW-1:0] idx;
  logic          found;

  assign diff = REQ ^ EN;

  // Pick the first differing bit at or above ptr, wrapping round.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!found && diff[j]) begin
        idx   = PW'(j);
        found = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered enables and status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      EN    <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else if (FORCE_OFF) begin
      EN    <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            EN[idx] <= ~EN[idx];
            ptr     <= PW'((int'(idx) + 1) % N);
            cnt     <= CW'(STAGGER - 1);
            BUSY    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (found) begin
            EN[idx] <= ~EN[idx];
            ptr     <= PW'((int'(idx) + 1) % N);
            cnt     <= CW'(STAGGER - 1);
          end else begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkbranch_seq.sv
// Directed bench for the clock-branch sequencer.
// Covers reset, stagger timing, wrap, revert, force-off and STAGGER=1.
module tb_gf180mcu_osu_sc_12t_clkbranch_seq;

  logic       clk = 1'b0;
  logic       rst, force_off;
  logic [3:0] req;
  logic [3:0] en;
  logic       busy, done;

  logic       rst1, force_off1;
  logic [3:0] req1;
  logic [3:0] en1;
  logic       busy1, done1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gf180mcu_osu_sc_12t_clkbranch_seq #(.N(4), .STAGGER(3)) u_dut (
    .CLK(clk), .RST(rst), .REQ(req), .FORCE_OFF(force_off),
    .EN(en), .BUSY(busy), .DONE(done)
  );

  gf180mcu_osu_sc_12t_clkbranch_seq #(.N(4), .STAGGER(1)) u_dut1 (
    .CLK(clk), .RST(rst1), .REQ(req1), .FORCE_OFF(force_off1),
    .EN(en1), .BUSY(busy1), .DONE(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] e,
                      input logic b, input logic d);
    chk({tag, " EN"}, 32'(en), 32'(e));
    chk({tag, " BUSY"}, 32'(busy), 32'(b));
    chk({tag, " DONE"}, 32'(done), 32'(d));
  endtask

  initial begin
    rst = 1'b1; force_off = 1'b0; req = 4'hF;
    rst1 = 1'b1; force_off1 = 1'b0; req1 = 4'h0;

    // 1: reset held two cycles with REQ all ones
    step(); chk3("rst e1", 4'h0, 1'b0, 1'b0);
    step(); chk3("rst e2", 4'h0, 1'b0, 1'b0);

    // 2: full ramp, toggles every 3 edges
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      logic [3:0] e;
      e = (k >= 10) ? 4'hF : (k >= 7) ? 4'h7 :
          (k >= 4) ? 4'h3 : 4'h1;
      step();
      chk3($sformatf("ramp e%0d", k), e, (k <= 12), (k == 13));
    end

    // 3: wrap-around from ptr=3
    rst = 1'b1; step(); chk3("wrap rst", 4'h0, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b0100;
    step(); chk3("wrap b2", 4'b0100, 1'b1, 1'b0);
    step(); step();
    step(); chk3("wrap done1", 4'b0100, 1'b0, 1'b1);
    req = 4'b0111;
    step(); chk3("wrap e1", 4'b0101, 1'b1, 1'b0);
    step(); chk3("wrap e2", 4'b0101, 1'b1, 1'b0);
    step(); step(); chk3("wrap e4", 4'b0111, 1'b1, 1'b0);
    step(); step();
    step(); chk3("wrap e7", 4'b0111, 1'b0, 1'b1);

    // 4: request reverts after first toggle
    rst = 1'b1; req = 4'hF; step();
    rst = 1'b0;
    step(); chk3("rev e1", 4'b0001, 1'b1, 1'b0);
    req = 4'b0001;
    step(); chk3("rev e2", 4'b0001, 1'b1, 1'b0);
    step(); chk3("rev e3", 4'b0001, 1'b1, 1'b0);
    step(); chk3("rev e4", 4'b0001, 1'b0, 1'b1);
    step(); chk3("rev e5", 4'b0001, 1'b0, 1'b0);

    // reset mid-sequence: no DONE, all cleared
    req = 4'hF;
    step(); chk3("mrst tog", 4'b0011, 1'b1, 1'b0);
    rst = 1'b1;
    step(); chk3("mrst", 4'h0, 1'b0, 1'b0);

    // 5: force-off mid-sequence, then restart
    rst = 1'b0;
    step(); chk("fo e1", 32'(en), 32'h1);
    step(); step();
    step(); chk("fo e4", 32'(en), 32'h3);
    force_off = 1'b1;
    step(); chk3("fo hit", 4'h0, 1'b0, 1'b0);
    step(); chk3("fo held", 4'h0, 1'b0, 1'b0);
    force_off = 1'b0; req = 4'b0011;
    step(); chk3("fo r1", 4'b0001, 1'b1, 1'b0);
    step(); step();
    step(); chk3("fo r4", 4'b0011, 1'b1, 1'b0);
    step(); step();
    step(); chk3("fo r7", 4'b0011, 1'b0, 1'b1);

    // 6: STAGGER=1 toggles on consecutive edges
    rst1 = 1'b0; req1 = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] e;
      e = (k >= 4) ? 4'hF : (k == 3) ? 4'h7 :
          (k == 2) ? 4'h3 : 4'h1;
      step();
      chk($sformatf("s1 e%0d EN", k), 32'(en1), 32'(e));
      chk($sformatf("s1 e%0d BUSY", k), 32'(busy1), 32'(k <= 4));
      chk($sformatf("s1 e%0d DONE", k), 32'(done1), 32'(k == 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
